// File: rtl/parking_pkg.sv
// Shared definitions for the parking gate keypad front end: key codes,
// PIN width and the one-hot entry state encoding.
package parking_pkg;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;
  localparam int         PIN_W     = 8;

  // One-hot entry states, same style as the gate controller's states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_ENTRY = 3'b010,
    ST_SEND  = 3'b100
  } entry_state_t;

endpackage

// File: rtl/pin_keypad_entry_if.sv
// Bundle of keypad-side and controller-side signals of the PIN entry block.
//
// Handshakes: a key transfers on a rising edge where key_valid && key_ready;
// a PIN transfers on a rising edge where pin_valid && pin_ready. Once
// pin_valid is high, pin and pin_valid hold until the transfer; the source
// never withdraws valid on its own (only reset drops it).
interface pin_keypad_entry_if;
  import parking_pkg::*;

  logic             key_valid;
  logic [3:0]       key_code;
  logic             key_ready;
  logic [PIN_W-1:0] pin;
  logic             pin_valid;
  logic             pin_ready;
  logic [1:0]       digit_count;
  logic             entry_err;
  logic             entry_timeout;
  entry_state_t     dbg_state;

  // Keypad + controller side.
  modport master (
    output key_valid, key_code, pin_ready,
    input  key_ready, pin, pin_valid, digit_count, entry_err, entry_timeout,
           dbg_state
  );

  // PIN entry block side.
  modport slave (
    input  key_valid, key_code, pin_ready,
    output key_ready, pin, pin_valid, digit_count, entry_err, entry_timeout,
           dbg_state
  );

endinterface

// File: rtl/pin_keypad_entry_timer.sv
// Inactivity timer for the ENTRY state. Counts idle cycles while enabled and
// flags expiry on the last allowed idle cycle; an accepted key (reload)
// always wins over expiry in the same cycle.
module entry_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic reload,
  output logic expired
);

  localparam int                CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // Idle counter: cleared outside ENTRY and on every accepted key, saturates at LAST.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (!enable || reload) begin
      r_cnt <= '0;
    end else if (r_cnt != LAST) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign expired = enable && !reload && (r_cnt == LAST);

endmodule

// File: rtl/pin_keypad_entry.sv
// Keypad front end: collects two decimal digits into a PIN, handles CLEAR,
// ENTER, malformed entries and inactivity timeout, and offers complete PINs
// to the gate controller over a valid/ready handshake.
module pin_keypad_entry
  import parking_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic               clock,
  input  logic               reset,
  pin_keypad_entry_if.slave  bus
);

  entry_state_t r_state, w_state_nxt;
  logic [6:0]   r_acc,   w_acc_nxt;
  logic [1:0]   r_count, w_count_nxt;
  logic         r_err,   w_err_nxt;
  logic         r_tmo,   w_tmo_nxt;
  logic         w_key_acc;
  logic         w_is_digit;
  logic         w_timer_en;
  logic         w_expired;

  assign w_key_acc  = bus.key_valid && (r_state != ST_SEND);
  assign w_is_digit = (bus.key_code <= 4'd9);
  assign w_timer_en = (r_state == ST_ENTRY);

  entry_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .enable  (w_timer_en),
    .reload  (w_key_acc),
    .expired (w_expired)
  );

  // State, accumulator and one-cycle event pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_count <= w_count_nxt;
      r_err   <= w_err_nxt;
      r_tmo   <= w_tmo_nxt;
    end
  end

  // Next-state logic; an accepted key takes priority over timer expiry.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_count_nxt = r_count;
    w_err_nxt   = 1'b0;
    w_tmo_nxt   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_key_acc) begin
          if (w_is_digit) begin
            w_state_nxt = ST_ENTRY;
            w_acc_nxt   = {3'b000, bus.key_code};
            w_count_nxt = 2'd1;
          end else if (bus.key_code == KEY_ENTER) begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_ENTRY: begin
        if (w_key_acc) begin
          if (w_is_digit) begin
            if (r_count == 2'd1) begin
              w_acc_nxt   = (r_acc * 7'd10) + {3'b000, bus.key_code};
              w_count_nxt = 2'd2;
            end else begin
              w_err_nxt = 1'b1;
            end
          end else if (bus.key_code == KEY_CLEAR) begin
            w_state_nxt = ST_IDLE;
            w_acc_nxt   = '0;
            w_count_nxt = '0;
          end else if (bus.key_code == KEY_ENTER) begin
            if (r_count == 2'd2) begin
              w_state_nxt = ST_SEND;
            end else begin
              w_err_nxt   = 1'b1;
              w_state_nxt = ST_IDLE;
              w_acc_nxt   = '0;
              w_count_nxt = '0;
            end
          end
        end else if (w_expired) begin
          w_tmo_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
          w_acc_nxt   = '0;
          w_count_nxt = '0;
        end
      end
      ST_SEND: begin
        if (bus.pin_ready) begin
          w_state_nxt = ST_IDLE;
          w_acc_nxt   = '0;
          w_count_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_acc_nxt   = '0;
        w_count_nxt = '0;
      end
    endcase
  end

  assign bus.key_ready     = (r_state != ST_SEND);
  assign bus.pin_valid     = (r_state == ST_SEND);
  assign bus.pin           = (r_state == ST_SEND) ? {1'b0, r_acc} : '0;
  assign bus.digit_count   = r_count;
  assign bus.entry_err     = r_err;
  assign bus.entry_timeout = r_tmo;
  assign bus.dbg_state     = r_state;

endmodule

// File: tb/tb_pin_keypad_entry.sv
// Bench for pin_keypad_entry: directed scenarios plus random key streams,
// checked against a digit-list reference model and a PIN scoreboard.
module tb_pin_keypad_entry;
  import parking_pkg::*;

  localparam int TC = 8;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [PIN_W-1:0] exp_q[$];

  pin_keypad_entry_if bus ();

  pin_keypad_entry #(.TIMEOUT_CYCLES(TC)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endfunction

  // Reference model: the entry is just a list of typed digits; the timeout
  // is a count of consecutive cycles with digits held and no accepted key.
  int        m_digits[$];
  bit        m_sending;
  int        m_idle;
  int        m_pin;
  bit        m_err;
  bit        m_tmo;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_digits.delete();
      m_sending = 1'b0;
      m_idle    = 0;
      m_pin     = 0;
      m_err     = 1'b0;
      m_tmo     = 1'b0;
      exp_q.delete();
    end else begin
      m_err = 1'b0;
      m_tmo = 1'b0;
      if (m_sending) begin
        if (bus.pin_ready) begin
          m_sending = 1'b0;
          m_pin     = 0;
          m_digits.delete();
        end
      end else if (bus.key_valid) begin
        m_idle = 0;
        if (bus.key_code <= 4'd9) begin
          if (m_digits.size() < 2) m_digits.push_back(int'(bus.key_code));
          else m_err = 1'b1;
        end else if (bus.key_code == KEY_CLEAR) begin
          m_digits.delete();
        end else if (bus.key_code == KEY_ENTER) begin
          if (m_digits.size() == 2) begin
            m_pin     = m_digits[0] * 10 + m_digits[1];
            m_sending = 1'b1;
            exp_q.push_back(PIN_W'(m_pin));
          end else begin
            m_err = 1'b1;
            m_digits.delete();
          end
        end
      end else if (m_digits.size() > 0) begin
        m_idle++;
        if (m_idle == TC) begin
          m_tmo  = 1'b1;
          m_idle = 0;
          m_digits.delete();
        end
      end
    end
  end

  // Monitor: per-cycle output checks and PIN scoreboard at each transfer.
  always @(negedge clk) begin
    logic [PIN_W-1:0] exp_pin;
    check("key_ready",     int'(bus.key_ready),     int'(!m_sending));
    check("pin_valid",     int'(bus.pin_valid),     int'(m_sending));
    check("pin",           int'(bus.pin),           m_sending ? m_pin : 0);
    check("digit_count",   int'(bus.digit_count),   m_digits.size());
    check("entry_err",     int'(bus.entry_err),     int'(m_err));
    check("entry_timeout", int'(bus.entry_timeout), int'(m_tmo));
    if (bus.pin_valid && bus.pin_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_pin", int'(bus.pin), -1);
      end else begin
        exp_pin = exp_q.pop_front();
        check("sb_pin", int'(bus.pin), int'(exp_pin));
      end
    end
  end

  // Driver tasks (inputs change 1 time unit after the rising edge)
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] code);
    int waited = 0;
    while (!bus.key_ready && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!bus.key_ready) check("key_ready_wait", int'(bus.key_ready), 1);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
  endtask

  task automatic consume(input int hold);
    int waited = 0;
    while (!bus.pin_valid && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!bus.pin_valid) check("pin_valid_wait", int'(bus.pin_valid), 1);
    idle(hold);
    bus.pin_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.pin_ready = 1'b0;
  endtask

  // Stimulus
  initial begin
    int          r;
    logic [3:0]  code;

    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    bus.pin_ready = 1'b0;
    rst_n         = 1'b0;
    idle(3);
    check("rst_key_ready",   int'(bus.key_ready),     1);
    check("rst_pin",         int'(bus.pin),           0);
    check("rst_pin_valid",   int'(bus.pin_valid),     0);
    check("rst_digit_count", int'(bus.digit_count),   0);
    check("rst_entry_err",   int'(bus.entry_err),     0);
    check("rst_timeout",     int'(bus.entry_timeout), 0);
    check("rst_state",       int'(bus.dbg_state),     int'(ST_IDLE));
    rst_n = 1'b1;
    idle(1);

    // 7, 2, ENTER with the controller stalling for 5 cycles
    press(4'd7);
    check("t1_count1", int'(bus.digit_count), 1);
    press(4'd2);
    check("t1_count2", int'(bus.digit_count), 2);
    press(KEY_ENTER);
    for (int k = 0; k < 5; k++) begin
      check("t1_pin",       int'(bus.pin),       72);
      check("t1_pin_valid", int'(bus.pin_valid), 1);
      check("t1_key_ready", int'(bus.key_ready), 0);
      idle(1);
    end
    bus.pin_ready = 1'b1;
    idle(1);
    bus.pin_ready = 1'b0;
    check("t1_post_valid", int'(bus.pin_valid),   0);
    check("t1_post_ready", int'(bus.key_ready),   1);
    check("t1_post_pin",   int'(bus.pin),         0);
    check("t1_post_count", int'(bus.digit_count), 0);
    check("t1_post_state", int'(bus.dbg_state),   int'(ST_IDLE));

    // Leading zero and maximum value
    press(4'd0); press(4'd5); press(KEY_ENTER);
    check("t2_pin_5", int'(bus.pin), 5);
    consume(0);
    press(4'd9); press(4'd9); press(KEY_ENTER);
    check("t2_pin_99", int'(bus.pin), 99);
    consume(2);

    // One digit then ENTER: error, entry discarded
    press(4'd3); press(KEY_ENTER);
    check("t3_err",       int'(bus.entry_err),   1);
    check("t3_pin_valid", int'(bus.pin_valid),   0);
    check("t3_count",     int'(bus.digit_count), 0);
    idle(1);
    check("t3_err_end", int'(bus.entry_err), 0);

    // Third digit discarded with an error
    press(4'd1); press(4'd2); press(4'd3);
    check("t4_err",   int'(bus.entry_err),   1);
    check("t4_count", int'(bus.digit_count), 2);
    press(KEY_ENTER);
    check("t4_pin_12", int'(bus.pin), 12);
    consume(1);

    // CLEAR mid-entry
    press(4'd4); press(KEY_CLEAR);
    check("t5_count_clr", int'(bus.digit_count), 0);
    press(4'd1); press(4'd8); press(KEY_ENTER);
    check("t5_pin_18", int'(bus.pin), 18);
    consume(0);

    // Ignored code mid-entry
    press(4'd5); press(4'hE);
    check("t6_count", int'(bus.digit_count), 1);
    check("t6_err",   int'(bus.entry_err),   0);
    check("t6_ready", int'(bus.key_ready),   1);
    press(KEY_CLEAR);

    // Inactivity timeout
    press(4'd6);
    idle(TC - 1);
    check("t7_no_tmo_yet", int'(bus.entry_timeout), 0);
    check("t7_count_held", int'(bus.digit_count),   1);
    idle(1);
    check("t7_tmo",   int'(bus.entry_timeout), 1);
    check("t7_state", int'(bus.dbg_state),     int'(ST_IDLE));
    check("t7_count", int'(bus.digit_count),   0);
    idle(1);
    check("t7_tmo_end", int'(bus.entry_timeout), 0);

    // Key arriving on the expiry cycle wins
    press(4'd6);
    idle(TC - 1);
    press(4'd3);
    check("t8_no_tmo", int'(bus.entry_timeout), 0);
    check("t8_count",  int'(bus.digit_count),   2);
    check("t8_state",  int'(bus.dbg_state),     int'(ST_ENTRY));
    press(KEY_ENTER);
    check("t8_pin_63", int'(bus.pin), 63);
    consume(0);

    // Reset while a PIN is pending
    press(4'd7); press(4'd2); press(KEY_ENTER);
    idle(2);
    check("t9_pin_72", int'(bus.pin), 72);
    #3;
    rst_n = 1'b0;
    #1;
    check("t9_pin_valid", int'(bus.pin_valid), 0);
    check("t9_pin",       int'(bus.pin),       0);
    check("t9_key_ready", int'(bus.key_ready), 1);
    check("t9_state",     int'(bus.dbg_state), int'(ST_IDLE));
    repeat (3) begin
      @(posedge clk);
      #1;
      check("t9_hold_valid", int'(bus.pin_valid),   0);
      check("t9_hold_count", int'(bus.digit_count), 0);
    end
    rst_n = 1'b1;
    idle(2);

    // Random key streams
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      code = 4'($urandom_range(0, 9));
      else if (r < 65) code = KEY_CLEAR;
      else if (r < 85) code = KEY_ENTER;
      else             code = 4'($urandom_range(12, 15));
      if ($urandom_range(0, 9) == 0) idle($urandom_range(TC - 3, TC + 4));
      else                           idle($urandom_range(0, 2));
      press(code);
      if (m_sending) consume($urandom_range(0, 4));
    end

    idle(TC + 4);
    check("sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pin_keypad_entry.md
# pin_keypad_entry

Keypad-side front end of the parking gate controller. Accepts decimal key presses, builds a two-digit PIN, and hands it to the gate controller FSM as a binary value over a valid/ready handshake. Handles clear, enter, malformed entries and an inactivity timeout, so the controller only ever sees complete PIN candidates.

## Interface
- `TIMEOUT_CYCLES`, default 1000: idle cycles allowed between key presses in ENTRY before the partial entry is discarded; must be ≥ 2.
- `clock`  in  1  single system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `key_valid`  in  1  keypad presents a key on `key_code`.
- `key_code`  in  4  0–9 are digits, 0xA is CLEAR, 0xB is ENTER, 0xC–0xF are ignored.
- `key_ready`  out  1  block accepts a key this cycle.
- `pin`  out  8  assembled PIN value, 0–99, zero-extended.
- `pin_valid`  out  1  `pin` holds a complete candidate.
- `pin_ready`  in  1  controller consumes `pin` this cycle.
- `digit_count`  out  2  digits held in the current entry, 0–2.
- `entry_err`  out  1  one-cycle pulse on a malformed entry.
- `entry_timeout`  out  1  one-cycle pulse when the inactivity timeout fires.

## Operation
- A key is accepted only when `key_valid && key_ready`.
- States:
  - **IDLE**: no digits held. A digit goes to ENTRY with acc = digit and count = 1. CLEAR is a no-op. ENTER pulses `entry_err` and stays in IDLE.
  - **ENTRY**: 1 or 2 digits held.
    - A digit with count = 1 sets acc = acc*10 + digit and count = 2.
    - A digit with count = 2 is discarded: pulse `entry_err`, acc unchanged.
    - CLEAR returns to IDLE with acc = 0 and count = 0.
    - ENTER with count = 2 goes to SEND.
    - ENTER with count = 1 pulses `entry_err` and returns to IDLE with the entry cleared.
    - Timeout returns to IDLE with the entry cleared and pulses `entry_timeout`.
  - **SEND**: `pin_valid` = 1, `pin` = acc, `key_ready` = 0. When `pin_ready` = 1 the PIN is consumed: go to IDLE, clear acc and count.
- Codes 0xC–0xF are consumed (`key_ready` stays 1) with no other effect and no error.
- Arithmetic: acc is 7 bits; max value 9*10 + 9 = 99, so no overflow is possible. `pin` = {1'b0, acc}.
- `key_ready` = 1 in IDLE and ENTRY, 0 in SEND.
- The block never retries or drops a PIN on its own. Retry counting and alarms belong to the controller.

## Timing
- Reset values: state = IDLE, acc = 0, count = 0, timer = 0.
  - `key_ready` = 1, `pin` = 0, `pin_valid` = 0, `digit_count` = 0, `entry_err` = 0, `entry_timeout` = 0.
- All outputs are registered, or decoded directly from registered state.
- Latency:
  - An accepted ENTER in cycle N gives `pin_valid` = 1 from cycle N+1.
  - `digit_count` updates in the cycle after a digit is accepted.
  - The `entry_err` pulse appears in the cycle after the offending key is accepted and lasts exactly 1 cycle.
- Handshake: `pin` and `pin_valid` are stable while `pin_valid && !pin_ready`. After `pin_ready` in cycle M:
  - `pin_valid` = 0 and `key_ready` = 1 in cycle M+1.
  - `pin` returns to 0 in cycle M+1.
- Timeout timer:
  - Counts only in ENTRY.
  - Reloads to 0 on every accepted key, including ignored codes.
  - Fires when the count reaches `TIMEOUT_CYCLES`-1 with no accepted key that cycle.
  - In the cycle after firing: state = IDLE and the `entry_timeout` pulse is present.
- Simultaneous events: an accepted key in the same cycle the timer would fire has priority. The key is processed normally and the timer reloads.
- Reset asserted mid-entry or in SEND clears everything asynchronously. A pending PIN is lost and `pin_valid` drops immediately.

## Structure
- Shared package `parking_pkg` holds:
  - key code constants KEY_CLEAR = 4'hA and KEY_ENTER = 4'hB;
  - PIN width constant PIN_W = 8;
  - the entry state encoding (one-hot, 3 states), in the same style as the controller's states.
- Sub-module `entry_timer` contains:
  - inputs: `clock`, `reset`, `enable`, `reload`;
  - output: `expired`;
  - parameter `TIMEOUT_CYCLES`;
  - a counter of width $clog2(`TIMEOUT_CYCLES`).
- The top level holds the FSM, the accumulator, and the output registers.

## Test plan
- Keys 7, 2, ENTER with `pin_ready` held 0 for 5 cycles, then 1:
  - `pin` = 72 and `pin_valid` = 1 from the cycle after ENTER, stable for 5 cycles;
  - `key_ready` = 0 throughout;
  - after the handshake, IDLE with `digit_count` = 0.
- Keys 0, 5, ENTER: `pin` = 5. Keys 9, 9, ENTER: `pin` = 99.
- Malformed entries:
  - Key 3 then ENTER: `entry_err` pulses for 1 cycle, `pin_valid` never rises, `digit_count` returns to 0.
  - Keys 1, 2, 3: the third digit pulses `entry_err`, and a following ENTER gives `pin` = 12.
- CLEAR and ignored codes:
  - Key 4, CLEAR, then 1, 8, ENTER: `pin` = 18.
  - Key 0xE mid-entry: no error, and `digit_count` is unchanged.
- Timeout with `TIMEOUT_CYCLES` = 8:
  - Key 6, then idle: `entry_timeout` pulses 8 cycles after the key is accepted, and the state is IDLE.
  - A key arriving exactly on the expiry cycle: no timeout, and the digit is accepted.
- Reset low while in SEND with `pin` = 72: `pin_valid` = 0 immediately, and all outputs hold their reset values until reset is released.
